keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Drives the column lines of a 4x4 matrix keypad and reads back its row lines.
//  Columns are scanned at a divided-clock rate. Rows are synchronised and
//  debounced, and each press produces one key code with a single-cycle valid strobe.
//  Sits between the keypad pins and the display/digit-shift logic.
//  It is the row-reading counterpart of the column-rate clock divider.
// PARAMETERS
//  SCAN_DIV        10000  clk cycles per column dwell (min 4); counter width $clog2(SCAN_DIV)
//  DEBOUNCE_SCANS  4      consecutive agreeing samples required to accept press or release (min 2)
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  reset_n    in   1  asynchronous, active-low reset
//  rows       in   4  keypad rows, active-low (external pull-ups), asynchronous to clk
//  cols       out  4  keypad column drive, active-low one-hot
//  key        out  4  hex code of last accepted key; holds until next accepted press
//  key_valid  out  1  one-cycle pulse when a new press is accepted
//  key_held   out  1  high from acceptance until debounced release
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - cols=4'b1110; key=0; key_valid=0; key_held=0.
//   - Dwell counter=0; state=SCAN; both stability counters=0.
//  Row input:
//   - rows pass through a 2-flop synchroniser before any use.
//   - Sample point = cycle where dwell counter == SCAN_DIV-1. The counter then wraps to 0.
//   - Only sample points are evaluated; rows are ignored on all other cycles.
//  Column advance:
//   - In SCAN only: column index 0->1->2->3->0 at each sample point with no row low.
//   - In DEBOUNCE and HELD the column is frozen.
//  Row select:
//   - If multiple rows are low, the lowest-index row wins.
//  Key map (row,col): r0=1,2,3,A; r1=4,5,6,B; r2=7,8,9,C; r3=E,0,F,D.
//  FSM:
//   SCAN:
//    - At a sample point with any row low: latch col and winning row, stable_cnt=1, go DEBOUNCE.
//   DEBOUNCE:
//    - At a sample point with the latched row low: stable_cnt++.
//    - When stable_cnt reaches DEBOUNCE_SCANS: register key, pulse key_valid, set key_held, go HELD.
//    - At a sample point with the latched row high: go SCAN and advance column. No output change.
//   HELD:
//    - At a sample point with the latched row high: rel_cnt++. Latched row low: rel_cnt=0.
//    - When rel_cnt reaches DEBOUNCE_SCANS: clear key_held, go SCAN, advance column.
//    - Other rows and columns are ignored while HELD (single-key rollover, no auto-repeat).
//  Latency:
//   - key_valid is high exactly on the cycle after the DEBOUNCE_SCANS-th agreeing sample.
//   - That is the detect sample + (DEBOUNCE_SCANS-1)*SCAN_DIV + 1 cycles.
//   - key and key_held update on the same edge as key_valid.
//  key_valid never asserts on two consecutive cycles, and never while key_held was already high.
//  Reset mid-press: return to reset values immediately. A still-pressed key is re-detected
//  from SCAN and accepted again after a full debounce.
// TESTING (bench uses SCAN_DIV=8, DEBOUNCE_SCANS=3)
//  1. Reset, no keys:
//     - cols cycles 1110,1101,1011,0111, changing every 8 clks.
//     - key_valid never asserts; key=0.
//  2. Hold row1 low whenever col2 is driven:
//     - One key_valid pulse with key=4'h6.
//     - It comes 17 clks after the detect sample; key_held=1.
//     - cols frozen at 1011 until release.
//  3. Bounce: row0 low for one sample at col0, then high:
//     - No key_valid.
//     - FSM returns to SCAN; cols moves to 1101 at the next sample point.
//  4. Press row3/col1 (key 0), release for 2 samples, re-press, then release 3 samples:
//     - Exactly one key_valid, key=4'h0.
//     - key_held drops only after the 3rd consecutive high sample.
//  5. Press (r0,c0); while HELD also press (r2,c0):
//     - Single key_valid with key=4'h1. The second key is ignored.
//     - After r0 releases and scanning resumes, r2 gives key=4'h7.
//  6. Assert reset_n=0 mid-DEBOUNCE:
//     - Outputs return to reset values asynchronously.
//     - After release with the key still held, key_valid comes only after a full 3-sample debounce.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the scanner, the keypad matrix and the
// downstream digit logic. The scanner owns the master side.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  rows,
    output cols,
    output key,
    output key_valid,
    output key_held
  );

  modport slave (
    output rows,
    input  cols,
    input  key,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives active-low columns at a divided rate, synchronises and
// debounces active-low rows, and emits one key code with a single-cycle strobe per press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 10000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input logic              clk,
  input logic              reset_n,
  keypad_scanner_if.master kp
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0] DebTarget = DebW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  logic [3:0]      rows_meta_q, rows_sync_q;
  logic [DivW-1:0] dwell_q, dwell_d;
  state_e          state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [3:0]      cols_q, cols_d;
  logic [1:0]      row_q, row_d;
  logic [DebW-1:0] stable_cnt_q, stable_cnt_d;
  logic [DebW-1:0] rel_cnt_q, rel_cnt_d;
  logic [3:0]      key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;

  logic       sample;
  logic       any_low;
  logic       row_low;
  logic       advance;
  logic [1:0] win_row;

  function automatic logic [3:0] key_code(logic [1:0] r, logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  always_comb begin
    sample  = (dwell_q == DivLast);
    any_low = ~&rows_sync_q;
    row_low = ~rows_sync_q[row_q];
    // Descending walk so the lowest-index low row is the one left standing.
    win_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_sync_q[i]) win_row = 2'(i);
    end
  end

  always_comb begin
    dwell_d      = sample ? '0 : dwell_q + DivW'(1);
    state_d      = state_q;
    col_d        = col_q;
    cols_d       = cols_q;
    row_d        = row_q;
    stable_cnt_d = stable_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    key_d        = key_q;
    key_valid_d  = 1'b0;
    key_held_d   = key_held_q;
    advance      = 1'b0;

    if (sample) begin
      unique case (state_q)
        StScan: begin
          if (any_low) begin
            // col_q stays put and serves as the latched column.
            row_d        = win_row;
            stable_cnt_d = DebW'(1);
            state_d      = StDebounce;
          end else begin
            advance = 1'b1;
          end
        end
        StDebounce: begin
          if (row_low) begin
            if (stable_cnt_q + DebW'(1) == DebTarget) begin
              key_d       = key_code(row_q, col_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rel_cnt_d   = '0;
              state_d     = StHeld;
            end else begin
              stable_cnt_d = stable_cnt_q + DebW'(1);
            end
          end else begin
            state_d = StScan;
            advance = 1'b1;
          end
        end
        StHeld: begin
          if (row_low) begin
            rel_cnt_d = '0;
          end else if (rel_cnt_q + DebW'(1) == DebTarget) begin
            rel_cnt_d  = '0;
            key_held_d = 1'b0;
            state_d    = StScan;
            advance    = 1'b1;
          end else begin
            rel_cnt_d = rel_cnt_q + DebW'(1);
          end
        end
        default: state_d = StScan;
      endcase
    end

    if (advance) begin
      col_d  = col_q + 2'd1;
      cols_d = {cols_q[2:0], cols_q[3]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows_meta_q  <= 4'hF;
      rows_sync_q  <= 4'hF;
      dwell_q      <= '0;
      state_q      <= StScan;
      col_q        <= 2'd0;
      cols_q       <= 4'b1110;
      row_q        <= 2'd0;
      stable_cnt_q <= '0;
      rel_cnt_q    <= '0;
      key_q        <= 4'h0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
    end else begin
      rows_meta_q  <= kp.rows;
      rows_sync_q  <= rows_meta_q;
      dwell_q      <= dwell_d;
      state_q      <= state_d;
      col_q        <= col_d;
      cols_q       <= cols_d;
      row_q        <= row_d;
      stable_cnt_q <= stable_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
    end
  end

  assign kp.cols      = cols_q;
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule
